// File: rtl/mux_n_reg.sv
// mux_n_reg: N-way WIDTH-bit selector with registered output, stall/flush and sticky select error
// Ports: clk, reset (sync, active-high); in_bus/in_vld (N flattened sources, source i at [i*WIDTH +: WIDTH]);
//        sel (source index, MODE 0 only); stall (hold outputs); flush (load bubble);
//        out_data/out_vld/out_src (registered selection); err (sticky out-of-range select).
module mux_n_reg #(
    parameter int WIDTH = 32,
    parameter int N = 8,
    parameter int SEL_W = 3,
    parameter int MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [N-1:0]       in_vld,
    input  logic [SEL_W-1:0]   sel,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_vld,
    output logic [SEL_W-1:0]   out_src,
    output logic               err
);
    logic [WIDTH-1:0] n_data;
    logic             n_vld;
    logic [SEL_W-1:0] n_src;
    logic             bad;
    // Descending scan in priority mode so the lowest valid index is the last write and wins.
    always_comb begin
        n_data = RESET_VAL;
        n_vld = 1'b0;
        n_src = '0;
        bad = 1'b0;
        if (MODE == 1) begin
            for (int i = N-1; i >= 0; i--)
                if (in_vld[i]) begin
                    n_data = in_bus[i*WIDTH +: WIDTH];
                    n_vld = 1'b1;
                    n_src = SEL_W'(i);
                end
        end else begin
            n_src = sel;
            bad = 1'b1;
            for (int i = 0; i < N; i++)
                if (sel == SEL_W'(i)) begin
                    n_data = in_bus[i*WIDTH +: WIDTH];
                    n_vld = in_vld[i];
                    bad = 1'b0;
                end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= RESET_VAL;
            out_vld <= 1'b0;
            out_src <= '0;
            err <= 1'b0;
        end else if (flush) begin
            out_data <= RESET_VAL;
            out_vld <= 1'b0;
            out_src <= '0;
        end else if (!stall) begin
            out_data <= n_data;
            out_vld <= n_vld;
            out_src <= n_src;
            err <= err | bad;
        end
    end
endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed table plus randomized model check of mux_n_reg in indexed (N=8, N=6) and priority modes
module tb_mux_n_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, flush, stall;
    logic [2:0] sel;
    logic [7:0] vld;
    logic [255:0] bus;
    logic [31:0] d0, d1, d2;
    logic v0, v1, v2, e0, e1, e2;
    logic [2:0] s0, s1, s2;
    int n_chk = 0, n_err = 0;
    mux_n_reg #(.WIDTH(32), .N(8), .SEL_W(3), .MODE(0), .RESET_VAL(32'h0)) u0 (
        .clk(clk), .reset(reset), .in_bus(bus), .in_vld(vld), .sel(sel), .stall(stall), .flush(flush),
        .out_data(d0), .out_vld(v0), .out_src(s0), .err(e0));
    mux_n_reg #(.WIDTH(32), .N(6), .SEL_W(3), .MODE(0), .RESET_VAL(32'h0)) u1 (
        .clk(clk), .reset(reset), .in_bus(bus[191:0]), .in_vld(vld[5:0]), .sel(sel), .stall(stall), .flush(flush),
        .out_data(d1), .out_vld(v1), .out_src(s1), .err(e1));
    mux_n_reg #(.WIDTH(32), .N(8), .SEL_W(3), .MODE(1), .RESET_VAL(32'h0)) u2 (
        .clk(clk), .reset(reset), .in_bus(bus), .in_vld(vld), .sel(sel), .stall(stall), .flush(flush),
        .out_data(d2), .out_vld(v2), .out_src(s2), .err(e2));
    typedef struct packed {
        logic [31:0] d;
        logic v;
        logic [2:0] s;
        logic e;
    } st_t;
    typedef struct packed {
        logic [1:0] t;
        logic r, f, st;
        logic [2:0] sl;
        logic [7:0] vl;
        logic [31:0] d;
        logic v;
        logic [2:0] s;
        logic e;
    } vec_t;
    localparam int NV = 26;
    vec_t tbl [NV];
    st_t m [3];
    function automatic st_t obs(int k);
        if (k == 0) return '{d: d0, v: v0, s: s0, e: e0};
        if (k == 1) return '{d: d1, v: v1, s: s1, e: e1};
        return '{d: d2, v: v2, s: s2, e: e2};
    endfunction
    function automatic st_t model(int md, int n, st_t c, logic r, logic f, logic st,
                                  logic [2:0] sl, logic [7:0] vl, logic [255:0] b);
        st_t x = c;
        int q[$];
        if (r) return '0;
        if (f) return '{d: 32'h0, v: 1'b0, s: 3'd0, e: c.e};
        if (st) return c;
        if (md == 0) begin
            x.s = sl;
            if (int'(sl) < n) begin
                x.d = b[int'(sl)*32 +: 32];
                x.v = vl[sl];
            end else begin
                x.d = 32'h0;
                x.v = 1'b0;
                x.e = 1'b1;
            end
        end else begin
            for (int i = 0; i < n; i++) if (vl[i]) q.push_back(i);
            if (q.size() > 0) x = '{d: b[q[0]*32 +: 32], v: 1'b1, s: 3'(q[0]), e: c.e};
            else x = '{d: 32'h0, v: 1'b0, s: 3'd0, e: c.e};
        end
        return x;
    endfunction
    task automatic chk(string nm, st_t got, st_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got d=%h v=%b s=%0d e=%b, want d=%h v=%b s=%0d e=%b",
                     nm, got.d, got.v, got.s, got.e, exp.d, exp.v, exp.s, exp.e);
        end
    endtask
    task automatic step(logic r, logic f, logic st, logic [2:0] sl, logic [7:0] vl);
        reset = r;
        flush = f;
        stall = st;
        sel = sl;
        vld = vl;
        @(posedge clk);
        #1;
    endtask
    initial begin
        st_t ex;
        reset = 1'b1; flush = 1'b0; stall = 1'b0; sel = '0; vld = '0;
        for (int i = 0; i < 8; i++) bus[i*32 +: 32] = 32'hA000_0000 + i;
        tbl = '{
            '{2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 32'h0,         1'b0, 3'd0, 1'b0},
            '{2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 32'h0,         1'b0, 3'd0, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b0, 3'd5, 8'hFF, 32'hA000_0005, 1'b1, 3'd5, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b0, 3'd4, 8'hFF, 32'hA000_0004, 1'b1, 3'd4, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b0, 3'd6, 8'hFF, 32'hA000_0006, 1'b1, 3'd6, 1'b0},
            '{2'd1, 1'b0, 1'b0, 1'b0, 3'd7, 8'hFF, 32'h0,         1'b0, 3'd7, 1'b1},
            '{2'd1, 1'b0, 1'b0, 1'b0, 3'd2, 8'hFF, 32'hA000_0002, 1'b1, 3'd2, 1'b1},
            '{2'd1, 1'b1, 1'b0, 1'b0, 3'd2, 8'hFF, 32'h0,         1'b0, 3'd0, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b0, 3'd3, 8'hFF, 32'hA000_0003, 1'b1, 3'd3, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 32'hA000_0003, 1'b1, 3'd3, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 32'hA000_0003, 1'b1, 3'd3, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 32'hA000_0003, 1'b1, 3'd3, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b0, 3'd1, 8'hFF, 32'hA000_0001, 1'b1, 3'd1, 1'b0},
            '{2'd1, 1'b0, 1'b0, 1'b0, 3'd7, 8'hFF, 32'h0,         1'b0, 3'd7, 1'b1},
            '{2'd1, 1'b0, 1'b0, 1'b0, 3'd2, 8'hFF, 32'hA000_0002, 1'b1, 3'd2, 1'b1},
            '{2'd1, 1'b0, 1'b1, 1'b1, 3'd2, 8'hFF, 32'h0,         1'b0, 3'd0, 1'b1},
            '{2'd1, 1'b1, 1'b1, 1'b0, 3'd2, 8'hFF, 32'h0,         1'b0, 3'd0, 1'b0},
            '{2'd0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h0F, 32'hA000_0005, 1'b0, 3'd5, 1'b0},
            '{2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 8'h28, 32'hA000_0003, 1'b1, 3'd3, 1'b0},
            '{2'd2, 1'b0, 1'b0, 1'b0, 3'd7, 8'h28, 32'hA000_0003, 1'b1, 3'd3, 1'b0},
            '{2'd2, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 32'h0,         1'b0, 3'd0, 1'b0},
            '{2'd2, 1'b0, 1'b0, 1'b0, 3'd1, 8'h80, 32'hA000_0007, 1'b1, 3'd7, 1'b0},
            '{2'd2, 1'b0, 1'b0, 1'b1, 3'd2, 8'h01, 32'hA000_0007, 1'b1, 3'd7, 1'b0},
            '{2'd2, 1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 32'hA000_0000, 1'b1, 3'd0, 1'b0},
            '{2'd1, 1'b0, 1'b0, 1'b0, 3'd5, 8'hFF, 32'hA000_0005, 1'b1, 3'd5, 1'b1},
            '{2'd1, 1'b0, 1'b0, 1'b0, 3'd6, 8'hFF, 32'h0,         1'b0, 3'd6, 1'b1}
        };
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].st, tbl[i].sl, tbl[i].vl);
            chk($sformatf("vec%0d_dut%0d", i, tbl[i].t), obs(int'(tbl[i].t)),
                '{d: tbl[i].d, v: tbl[i].v, s: tbl[i].s, e: tbl[i].e});
        end
        step(1'b0, 1'b0, 1'b0, 3'd7, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 3'd7, 8'hFF);
        chk("reset_over_stall_dut1", obs(1), '0);
        chk("reset_over_stall_dut0", obs(0), '0);
        for (int k = 0; k < 3; k++) m[k] = '0;
        for (int c = 0; c < 1000; c++) begin
            logic r, f, st;
            logic [2:0] sl;
            logic [7:0] vl;
            r = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 9) == 0);
            sl = 3'($urandom);
            vl = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            for (int i = 0; i < 8; i++) bus[i*32 +: 32] = $urandom;
            m[0] = model(0, 8, m[0], r, f, st, sl, vl, bus);
            m[1] = model(0, 6, m[1], r, f, st, sl, vl, bus);
            m[2] = model(1, 8, m[2], r, f, st, sl, vl, bus);
            step(r, f, st, sl, vl);
            for (int k = 0; k < 3; k++) begin
                ex = m[k];
                chk($sformatf("rand%0d_dut%0d", c, k), obs(k), ex);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-way, W-bit selector with a registered output stage, for pipeline-stage operand and forwarding selection in the CPU datapath.
- Two selection modes:
  - Indexed: an explicit select picks the source.
  - Priority: the lowest-index valid source wins.
- The output register supports stall (hold) and flush (bubble), tracks output validity and reports which source was taken.
- A sticky error flag catches out-of-range selects.

Parameters:
- WIDTH, 32, data width per source.
- N, 8, number of sources (2..16).
- SEL_W, 3, select/source-index width; must satisfy 2**SEL_W >= N.
- MODE, 0, 0 = indexed by sel; 1 = priority on in_vld (sel ignored).
- RESET_VAL, 32'h0000_0000, value loaded into out_data on reset, flush or invalid selection (truncated to WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_bus  input  N*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- in_vld  input  N  per-source valid.
- sel  input  SEL_W  source index (MODE 0 only).
- stall  input  1  hold all registered outputs this cycle.
- flush  input  1  load a bubble this cycle.
- out_data  output  WIDTH  registered selected data.
- out_vld  output  1  registered valid of the selected source.
- out_src  output  SEL_W  registered index of the selected source.
- err  output  1  sticky out-of-range-select flag.

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs. Latency is exactly 1 cycle.
- Reset and flush are evaluated only at the rising edge of clk.
- Per-edge priority: reset > flush > stall > load.
- reset=1:
  - out_data=RESET_VAL, out_vld=0, out_src=0, err=0.
  - Reset wins over a simultaneous stall or flush and aborts any held value.
- flush=1 (reset=0):
  - out_data=RESET_VAL, out_vld=0, out_src=0.
  - err is unchanged.
  - Flush wins over stall.
- stall=1 (reset=0, flush=0):
  - out_data, out_vld, out_src and err all hold.
  - No sampling of in_bus, in_vld or sel occurs.
- Load (reset=0, flush=0, stall=0), MODE 0:
  - sel < N: out_data=in_bus[sel], out_vld=in_vld[sel], out_src=sel.
  - sel >= N: out_data=RESET_VAL, out_vld=0, out_src=sel, err<=1.
  - err stays 1 until reset.
- Load, MODE 1:
  - k is the lowest index with in_vld[k]=1: out_data=in_bus[k], out_vld=1, out_src=k.
  - in_vld all zero: out_data=RESET_VAL, out_vld=0, out_src=0.
  - err is never set in MODE 1.
- Data moves bit-exact with no sign or zero extension. Unused select codes (N < 2**SEL_W) are handled only by the sel >= N rule.
- Back-to-back loads each take effect on consecutive edges with no bubbles.
- Releasing stall loads on the first edge where stall=0.

Test Plan:
- MODE 0, N=8, WIDTH=32, source i = 32'hA000_0000+i, all valid: reset for 2 cycles, then sel=5 -> next edge out_data=32'hA000_0005, out_vld=1, out_src=5, err=0.
- MODE 0, N=6, SEL_W=3, sel=7 -> out_data=0, out_vld=0, out_src=7, err=1. Then sel=2 -> out_data=32'hA000_0002 while err remains 1. Reset clears err.
- Stall hold: load sel=3 (32'hA000_0003), then stall=1 for 3 cycles with sel=1 -> out_data stays 32'hA000_0003 throughout. Release stall -> next edge shows 32'hA000_0001.
- Flush and priority: with out_vld=1, assert stall=1 and flush=1 together -> next edge out_vld=0, out_data=0, out_src=0, err unchanged. Assert reset=1 together with flush -> reset values.
- MODE 1, in_vld=8'b0010_1000 -> out_src=3, out_data=32'hA000_0003, out_vld=1. Then in_vld=0 -> out_vld=0, out_data=0, out_src=0. sel toggling has no effect.
- Randomised 1000 cycles against a reference model in both modes with random stall, flush and reset (each ~10%): exact match on all four outputs every cycle.
